// File: rtl/instruction_fetch.sv
// Fetch stage: drives PC to instruction memory, absorbs wait states and hands words to the
// decoder through an output register backed by a one-entry skid register.
module instruction_fetch #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [ADDR_WIDTH-1:0]  PC,
    output logic                   PC_EN,
    input  logic                   FLUSH,
    output logic [ADDR_WIDTH-1:0]  MEM_ADDRESS,
    output logic                   MEM_READ,
    input  logic [INSTR_WIDTH-1:0] MEM_READDATA,
    input  logic                   MEM_BUSYWAIT,
    output logic [INSTR_WIDTH-1:0] INSTRUCTION,
    output logic                   INSTR_VALID,
    input  logic                   INSTR_READY
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StAdvance,
        StHold,
        StDrain
    } state_e;

    state_e                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [INSTR_WIDTH-1:0] skid_q, skid_d;
    logic                   valid_q, valid_d;
    logic                   slot_free;

    assign slot_free = ~valid_q | INSTR_READY;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        skid_d  = skid_q;
        // A transfer empties the output register unless it is refilled below.
        valid_d = valid_q & ~INSTR_READY;

        if (FLUSH) begin
            valid_d = 1'b0;
            skid_d  = '0;
            // An outstanding memory request must still be completed, then discarded.
            case (state_q)
                StFetch, StDrain: state_d = MEM_BUSYWAIT ? StDrain : StFetch;
                default:          state_d = StFetch;
            endcase
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StFetch;
                end
                StFetch: begin
                    if (!MEM_BUSYWAIT) begin
                        if (slot_free) begin
                            instr_d = MEM_READDATA;
                            valid_d = 1'b1;
                            state_d = StAdvance;
                        end else begin
                            skid_d  = MEM_READDATA;
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    if (slot_free) begin
                        instr_d = skid_q;
                        valid_d = 1'b1;
                        state_d = StAdvance;
                    end
                end
                StAdvance: begin
                    state_d = StFetch;
                end
                StDrain: begin
                    if (!MEM_BUSYWAIT) begin
                        state_d = StFetch;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            instr_q <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
        end
    end

    // Moore outputs so an asynchronous reset drops the request immediately.
    assign MEM_READ    = (state_q == StFetch) || (state_q == StDrain);
    assign PC_EN       = (state_q == StAdvance);
    assign MEM_ADDRESS = PC;
    assign INSTRUCTION = instr_q;
    assign INSTR_VALID = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a PC counter and wait-state memory model around the DUT, with a
// queue of expected decoder words checked on every valid/ready transfer.
module tb_instruction_fetch;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  PC;
    logic        PC_EN;
    logic        FLUSH;
    logic [7:0]  MEM_ADDRESS;
    logic        MEM_READ;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;
    logic        INSTR_READY;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    logic [31:0] exp_q[$];

    // Program counter model
    logic       pc_load = 1'b0;
    logic [7:0] pc_load_val = 8'h00;
    int         pc_en_cnt = 0;

    // Memory model: ws wait-state cycles per read
    int ws = 0;
    int cnt = 0;

    instruction_fetch #(
        .ADDR_WIDTH (8),
        .INSTR_WIDTH(32)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PC          (PC),
        .PC_EN       (PC_EN),
        .FLUSH       (FLUSH),
        .MEM_ADDRESS (MEM_ADDRESS),
        .MEM_READ    (MEM_READ),
        .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT),
        .INSTRUCTION (INSTRUCTION),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (pc_load) begin
            PC <= pc_load_val;
        end else if (PC_EN) begin
            PC        <= PC + 8'd1;
            pc_en_cnt <= pc_en_cnt + 1;
        end
    end

    assign MEM_BUSYWAIT = MEM_READ && (cnt < ws);
    assign MEM_READDATA = 32'h1000_0000 + {24'h0, MEM_ADDRESS};

    always @(posedge CLK) begin
        if (!MEM_READ || !MEM_BUSYWAIT) cnt <= 0;
        else                            cnt <= cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    // One clock: scoreboard-check any transfer at the coming edge, return just after the edge.
    task automatic step();
        logic [31:0] e;
        @(negedge CLK);
        if (INSTR_VALID && INSTR_READY) begin
            xfers++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: unexpected word %h, expected none", INSTRUCTION);
            end else begin
                e = exp_q.pop_front();
                if (INSTRUCTION !== e) begin
                    errors++;
                    $display("FAIL scoreboard: got %h, expected %h", INSTRUCTION, e);
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] start_pc);
        RESET       = 1'b1;
        FLUSH       = 1'b0;
        INSTR_READY = 1'b0;
        pc_load     = 1'b1;
        pc_load_val = start_pc;
        exp_q.delete();
        step();
        pc_load = 1'b0;
        step();
        RESET = 1'b0;
    endtask

    task automatic test_leftover(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: got %0d undelivered words, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset(8'h30);
        ws = 3;
        repeat (6) step();
        // Now in FETCH for 0x31 with word 0x30 held unaccepted.
        checks++;
        if (!(MEM_READ === 1'b1 && INSTR_VALID === 1'b1)) begin
            errors++;
            $display("FAIL reset_pre: got read=%b valid=%b, expected 1 1", MEM_READ, INSTR_VALID);
        end
        #2 RESET = 1'b1;
        #1;
        checks++;
        if ({MEM_READ, PC_EN, INSTR_VALID} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async: got read/pc_en/valid=%b, expected 000",
                     {MEM_READ, PC_EN, INSTR_VALID});
        end
        checks++;
        if (INSTRUCTION !== 32'h0) begin
            errors++;
            $display("FAIL reset_instr: got %h, expected 00000000", INSTRUCTION);
        end
        step();
        RESET = 1'b0;
        checks++;
        if (MEM_READ !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got read=%b, expected 0", MEM_READ);
        end
        step();
        checks++;
        if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 8'h31) begin
            errors++;
            $display("FAIL reset_first_fetch: got read=%b addr=%h, expected 1 31",
                     MEM_READ, MEM_ADDRESS);
        end
    endtask

    task automatic test_zero_wait();
        int pe0, x0;
        do_reset(8'h00);
        ws = 0;
        INSTR_READY = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h1000_0000 + i);
        pe0 = pc_en_cnt;
        x0  = xfers;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (MEM_READ !== 1'b1 || PC_EN !== 1'b0 || MEM_ADDRESS !== 8'(i)) begin
                errors++;
                $display("FAIL zw_fetch%0d: got read=%b pc_en=%b addr=%h, expected 1 0 %h",
                         i, MEM_READ, PC_EN, MEM_ADDRESS, 8'(i));
            end
            step();
            checks++;
            if (INSTR_VALID !== 1'b1 || PC_EN !== 1'b1 || MEM_READ !== 1'b0 ||
                INSTRUCTION !== 32'h1000_0000 + i) begin
                errors++;
                $display("FAIL zw_adv%0d: got valid=%b pc_en=%b read=%b instr=%h, expected 1 1 0 %h",
                         i, INSTR_VALID, PC_EN, MEM_READ, INSTRUCTION, 32'h1000_0000 + i);
            end
            step();
        end
        checks++;
        if (PC !== 8'd3 || pc_en_cnt - pe0 != 3 || xfers - x0 != 3) begin
            errors++;
            $display("FAIL zw_count: got pc=%0d pulses=%0d xfers=%0d, expected 3 3 3",
                     PC, pc_en_cnt - pe0, xfers - x0);
        end
        test_leftover("zw");
    endtask

    task automatic test_wait_states();
        do_reset(8'h10);
        ws = 3;
        INSTR_READY = 1'b1;
        exp_q.push_back(32'h1000_0010);
        exp_q.push_back(32'h1000_0011);
        step();
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (MEM_READ !== 1'b1 || INSTR_VALID !== 1'b0 || MEM_ADDRESS !== 8'h10 + 8'(w)) begin
                    errors++;
                    $display("FAIL ws_wait%0d_%0d: got read=%b valid=%b addr=%h, expected 1 0 %h",
                             w, k, MEM_READ, INSTR_VALID, MEM_ADDRESS, 8'h10 + 8'(w));
                end
                step();
            end
            checks++;
            if (INSTR_VALID !== 1'b1 || PC_EN !== 1'b1 || MEM_READ !== 1'b0) begin
                errors++;
                $display("FAIL ws_adv%0d: got valid=%b pc_en=%b read=%b, expected 1 1 0",
                         w, INSTR_VALID, PC_EN, MEM_READ);
            end
            step();
        end
        test_leftover("ws");
    endtask

    task automatic test_backpressure();
        int x0;
        do_reset(8'h05);
        ws = 0;
        repeat (6) step();
        checks++;
        if (INSTRUCTION !== 32'h1000_0005 || INSTR_VALID !== 1'b1 || MEM_READ !== 1'b0 ||
            PC_EN !== 1'b0 || PC !== 8'h06) begin
            errors++;
            $display("FAIL bp_hold: got instr=%h valid=%b read=%b pc_en=%b pc=%h, expected 10000005 1 0 0 06",
                     INSTRUCTION, INSTR_VALID, MEM_READ, PC_EN, PC);
        end
        exp_q.push_back(32'h1000_0005);
        exp_q.push_back(32'h1000_0006);
        exp_q.push_back(32'h1000_0007);
        x0 = xfers;
        INSTR_READY = 1'b1;
        step();
        checks++;
        if (INSTRUCTION !== 32'h1000_0006 || INSTR_VALID !== 1'b1 || PC_EN !== 1'b1 ||
            xfers - x0 != 1) begin
            errors++;
            $display("FAIL bp_skid: got instr=%h valid=%b pc_en=%b xfers=%0d, expected 10000006 1 1 1",
                     INSTRUCTION, INSTR_VALID, PC_EN, xfers - x0);
        end
        step();
        checks++;
        if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 8'h07 || xfers - x0 != 2) begin
            errors++;
            $display("FAIL bp_resume: got read=%b addr=%h xfers=%0d, expected 1 07 2",
                     MEM_READ, MEM_ADDRESS, xfers - x0);
        end
        step();
        step();
        test_leftover("bp");
    endtask

    task automatic test_flush();
        int pe0, x0;
        do_reset(8'h20);
        ws = 3;
        repeat (6) step();
        // FETCH of 0x21 in its first busy cycle, word 0x20 unaccepted.
        FLUSH       = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = 8'h40;
        pe0 = pc_en_cnt;
        x0  = xfers;
        step();
        FLUSH   = 1'b0;
        pc_load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (MEM_READ !== 1'b1 || INSTR_VALID !== 1'b0 || PC_EN !== 1'b0) begin
                errors++;
                $display("FAIL fl_drain%0d: got read=%b valid=%b pc_en=%b, expected 1 0 0",
                         k, MEM_READ, INSTR_VALID, PC_EN);
            end
            step();
        end
        checks++;
        if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 8'h40 || INSTR_VALID !== 1'b0 ||
            pc_en_cnt != pe0) begin
            errors++;
            $display("FAIL fl_refetch: got read=%b addr=%h valid=%b pulses=%0d, expected 1 40 0 0",
                     MEM_READ, MEM_ADDRESS, INSTR_VALID, pc_en_cnt - pe0);
        end
        exp_q.push_back(32'h1000_0040);
        INSTR_READY = 1'b1;
        repeat (5) step();
        checks++;
        if (xfers - x0 != 1) begin
            errors++;
            $display("FAIL fl_xfers: got %0d transfers, expected 1", xfers - x0);
        end
        test_leftover("fl");
    endtask

    task automatic test_wrap();
        int x0;
        do_reset(8'hFF);
        ws = 0;
        INSTR_READY = 1'b1;
        exp_q.push_back(32'h1000_00FF);
        exp_q.push_back(32'h1000_0000);
        x0 = xfers;
        step();
        step();
        step();
        checks++;
        if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 8'h00 || xfers - x0 != 1) begin
            errors++;
            $display("FAIL wrap_addr: got read=%b addr=%h xfers=%0d, expected 1 00 1",
                     MEM_READ, MEM_ADDRESS, xfers - x0);
        end
        step();
        step();
        checks++;
        if (xfers - x0 != 2) begin
            errors++;
            $display("FAIL wrap_xfers: got %0d transfers, expected 2", xfers - x0);
        end
        test_leftover("wrap");
    endtask

    initial begin
        RESET       = 1'b1;
        FLUSH       = 1'b0;
        INSTR_READY = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_backpressure();
        test_flush();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between the 8-bit program counter and the instruction decoder. Drives the PC value to instruction memory, waits out memory wait states, and buffers the returned 32-bit word in a one-entry output register plus a one-entry skid register, presented to the decoder with a valid/ready handshake. It tells the program counter when to advance (PC_EN) and discards in-flight data on FLUSH, which the control unit asserts when it reloads the PC.

## Interface
- ADDR_WIDTH, 8, PC and memory address width (PC counts instruction words).
- INSTR_WIDTH, 32, instruction word width.
- CLK  input  1  clock; all state changes on posedge.
- RESET  input  1  asynchronous, active-high reset.
- PC  input  ADDR_WIDTH  current program counter value.
- PC_EN  output  1  PC increments at the posedge where this is high.
- FLUSH  input  1  discard buffered and in-flight instructions; PC has been reloaded.
- MEM_ADDRESS  output  ADDR_WIDTH  instruction memory address; combinational copy of PC.
- MEM_READ  output  1  read request.
- MEM_READDATA  input  INSTR_WIDTH  instruction word; valid at the edge where MEM_BUSYWAIT is sampled low with MEM_READ high.
- MEM_BUSYWAIT  input  1  memory not done.
- INSTRUCTION  output  INSTR_WIDTH  instruction to decoder.
- INSTR_VALID  output  1  INSTRUCTION holds a valid word.
- INSTR_READY  input  1  decoder accepts INSTRUCTION this edge.

## Operation
- States: IDLE, FETCH, ADVANCE, HOLD, DRAIN. Outputs Moore-decoded from state: MEM_READ=1 only in FETCH and DRAIN; PC_EN=1 only in ADVANCE.
- Transfer: INSTR_VALID & INSTR_READY at a posedge; INSTR_VALID clears that edge unless refilled the same edge.
- Output slot "free" at an edge: INSTR_VALID=0, or INSTR_READY=1.
- IDLE: next edge -> FETCH.
- FETCH: MEM_BUSYWAIT=1 -> stay. MEM_BUSYWAIT=0: slot free -> INSTRUCTION<=MEM_READDATA, INSTR_VALID<=1, -> ADVANCE; slot not free -> SKID<=MEM_READDATA, -> HOLD.
- HOLD: MEM_READ=0, PC_EN=0. When slot free: INSTRUCTION<=SKID, INSTR_VALID<=1, -> ADVANCE.
- ADVANCE: PC_EN=1 for exactly one cycle; next edge -> FETCH (PC now incremented).
- FLUSH (sampled at posedge, priority over all above except RESET): INSTR_VALID<=0, SKID discarded. From FETCH with MEM_BUSYWAIT=1 -> DRAIN. From FETCH with MEM_BUSYWAIT=0, or from HOLD/ADVANCE/IDLE -> FETCH; returning data discarded; PC_EN not asserted for discarded words.
- DRAIN: holds MEM_READ=1 until MEM_BUSYWAIT sampled low, data discarded, -> FETCH. A request is never abandoned mid-flight.
- MEM_ADDRESS follows PC combinationally; PC is stable in FETCH/DRAIN because PC_EN=0 there. PC wrap (0xFF->0x00) is the counter's concern; no special handling.

## Timing
- RESET asserted (any time, asynchronous): state=IDLE, MEM_READ=0, PC_EN=0, INSTR_VALID=0, INSTRUCTION=0, SKID=0. Mid-fetch reset drops MEM_READ immediately.
- First MEM_READ high in the 2nd cycle after RESET deasserts (IDLE, then FETCH).
- Zero wait states, INSTR_READY=1: FETCH, ADVANCE alternating; one instruction per 2 cycles; INSTR_VALID rises the edge after MEM_READ first seen with MEM_BUSYWAIT=0.
- N wait-state cycles add N cycles per fetch.
- Backpressure: at most two words held (INSTRUCTION+SKID); no fetch issued while SKID full.
- FLUSH and INSTR_READY at the same edge: flush wins; the transfer is still counted by decoder (it sampled INSTRUCTION), INSTR_VALID then 0.

## Test plan
- Reset: assert RESET mid-FETCH -> MEM_READ, PC_EN, INSTR_VALID fall immediately, INSTRUCTION=0x00000000; release -> MEM_READ=1 two cycles later with MEM_ADDRESS=PC.
- Zero-wait stream: memory returns 0x10000000+addr, READY=1, PC starts 0 -> INSTRUCTION sequence 0x10000000, 0x10000001, 0x10000002 every 2 cycles, PC_EN one-cycle pulses, PC=3 after third.
- Wait states: MEM_BUSYWAIT high 3 cycles per read -> MEM_READ held 4 cycles, word captured only on low edge, 5 cycles per instruction.
- Backpressure: READY=0 for 6 cycles from PC=5 -> INSTRUCTION=word5 stable, SKID=word6, PC stops at 6, MEM_READ=0; READY=1 -> word5 then word6 delivered on consecutive transfers, fetch resumes at 7.
- Flush during wait: FLUSH pulse in FETCH with MEM_BUSYWAIT=1, PC reloaded to 0x40 -> INSTR_VALID=0, MEM_READ stays high until busywait low, that data discarded, next fetch address 0x40, no PC_EN for discarded word.
- Wrap: PC=0xFF zero-wait -> word 0xFF delivered, next MEM_ADDRESS=0x00, no stall or duplicate.
